// File: rtl/pid_dterm_pkg.sv
// Shared constants and helpers for the multi-channel PID derivative-term engine.
package pid_dterm_pkg;

    // Default build parameters
    localparam int ERR_W_DEF   = 10;
    localparam int SAT_W_DEF   = 8;
    localparam int COEFF_W_DEF = 5;
    localparam int DEPTH_DEF   = 3;
    localparam int NUM_CH_DEF  = 2;

    // Channel-tag width; a single-channel build still carries a 1-bit tag
    function automatic int ch_w_f(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Saturated difference at the default width
    typedef logic signed [SAT_W_DEF-1:0] sat_t;

endpackage

// File: rtl/dterm_sat.sv
// Combinational signed clamp from IN_W bits down to OUT_W bits.
module dterm_sat #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic signed [OUT_W-1:0] dout_o
);

    if (IN_W > OUT_W) begin : g_clamp
        localparam logic signed [IN_W-1:0] HI = IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
        localparam logic signed [IN_W-1:0] LO = IN_W'(-(64'sd1 <<< (OUT_W - 1)));

        // Clamp to the representable output range
        always_comb begin
            // NOTE: dout_o gets a value before any branch, so no path can infer a latch.
            dout_o = din_i[OUT_W-1:0];
            if (din_i > HI) begin
                dout_o = HI[OUT_W-1:0];
            end else if (din_i < LO) begin
                dout_o = LO[OUT_W-1:0];
            end
        end
    end else begin : g_ext
        // Output is at least as wide as the input: plain sign extension
        assign dout_o = OUT_W'(din_i);
    end

endmodule

// File: rtl/pid_dterm_mc.sv
// Multi-channel PID derivative term: per-channel error history, saturated
// difference against the sample DEPTH back, scaled by d_coeff, two-stage pipeline.
// Optional feature macro: PID_DTERM_LPF_EN (per-channel first-order output smoothing).
module pid_dterm_mc
    import pid_dterm_pkg::*;
#(
    parameter int  ERR_W   = ERR_W_DEF,
    parameter int  SAT_W   = SAT_W_DEF,
    parameter int  COEFF_W = COEFF_W_DEF,
    parameter int  DEPTH   = DEPTH_DEF,
    parameter int  NUM_CH  = NUM_CH_DEF,
    localparam int CH_W    = ch_w_f(NUM_CH),
    localparam int PROD_W  = SAT_W + COEFF_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [ERR_W-1:0]   err_sat,
    input  logic        [CH_W-1:0]    err_ch,
    input  logic                      err_vld,
    input  logic                      hist_clr,
    input  logic signed [COEFF_W-1:0] d_coeff,
    output logic signed [PROD_W-1:0]  D_term,
    output logic        [CH_W-1:0]    D_ch,
    output logic                      D_vld
);

    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CH_W:0]    NUM_CH_C = (CH_W + 1)'(NUM_CH);

    // Per-channel history (index 0 = newest) and fill count
    logic signed [ERR_W-1:0] hist_q [NUM_CH][DEPTH];
    logic [CNT_W-1:0]        cnt_q  [NUM_CH];

    // Stage 0 (combinational)
    logic                    ch_ok;
    logic                    take;
    logic                    primed;
    logic [CNT_W-1:0]        cnt_cur;
    logic signed [ERR_W:0]   diff;
    logic signed [SAT_W-1:0] sat_s0;

    // Stage 1 registers
    logic                      s1_vld_q;
    logic signed [SAT_W-1:0]   s1_sat_q;
    logic signed [COEFF_W-1:0] s1_coeff_q;
    logic [CH_W-1:0]           s1_ch_q;

    // Stage 2 next-state
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] d_term_d;

`ifdef PID_DTERM_LPF_EN
    logic signed [PROD_W-1:0] lpf_q [NUM_CH];
    logic signed [PROD_W:0]   lpf_sum;
`endif

    // Stage 0: channel qualification and unwrapped difference (forced to 0 until primed)
    always_comb begin
        ch_ok   = ({1'b0, err_ch} < NUM_CH_C);
        take    = err_vld && ch_ok;
        cnt_cur = ch_ok ? cnt_q[err_ch] : '0;
        // A same-cycle clear empties the history before this sample is judged
        primed  = !hist_clr && (cnt_cur == CNT_FULL);
        diff    = '0;
        if (primed) begin
            diff = (ERR_W + 1)'(err_sat) - (ERR_W + 1)'(hist_q[err_ch][DEPTH-1]);
        end
    end

    dterm_sat #(
        .IN_W  (ERR_W + 1),
        .OUT_W (SAT_W)
    ) u_sat (
        .din_i  (diff),
        .dout_o (sat_s0)
    );

    // History shift / clear; clear acts first when it coincides with a sample
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the history is a small register file, not a RAM, so it takes the async reset.
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    hist_q[c][d] <= '0;
                end
            end
        end else if (ch_ok) begin
            if (err_vld) begin
                // NOTE: non-blocking updates mean hist_q[..][d-1] below is the pre-edge value.
                hist_q[err_ch][0] <= err_sat;
                for (int d = 1; d < DEPTH; d++) begin
                    hist_q[err_ch][d] <= hist_clr ? '0 : hist_q[err_ch][d-1];
                end
                if (hist_clr) begin
                    cnt_q[err_ch] <= CNT_ONE;
                end else if (cnt_q[err_ch] != CNT_FULL) begin
                    cnt_q[err_ch] <= cnt_q[err_ch] + CNT_ONE;
                end
            end else if (hist_clr) begin
                cnt_q[err_ch] <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    hist_q[err_ch][d] <= '0;
                end
            end
        end
    end

    // Stage 1: capture saturated difference, coefficient and tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_sat_q   <= '0;
            s1_coeff_q <= '0;
            s1_ch_q    <= '0;
        end else begin
            s1_vld_q <= take;
            if (take) begin
                s1_sat_q   <= sat_s0;
                s1_coeff_q <= d_coeff;
                s1_ch_q    <= err_ch;
            end
        end
    end

    // Stage 2 datapath: full-width signed product, optionally averaged with the channel's last output
    always_comb begin
        prod = PROD_W'(s1_sat_q) * PROD_W'(s1_coeff_q);
`ifdef PID_DTERM_LPF_EN
        lpf_sum  = (PROD_W + 1)'(prod) + (PROD_W + 1)'(lpf_q[s1_ch_q]);
        d_term_d = PROD_W'(lpf_sum >>> 1);
`else
        d_term_d = prod;
`endif
    end

    // Stage 2 output registers; term and tag hold between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D_vld  <= 1'b0;
            D_term <= '0;
            D_ch   <= '0;
        end else begin
            D_vld <= s1_vld_q;
            if (s1_vld_q) begin
                D_term <= d_term_d;
                D_ch   <= s1_ch_q;
            end
        end
    end

`ifdef PID_DTERM_LPF_EN
    // Smoothing state: follows each emitted term; a channel clear wins over a same-cycle update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                lpf_q[c] <= '0;
            end
        end else begin
            if (s1_vld_q) begin
                lpf_q[s1_ch_q] <= d_term_d;
            end
            if (hist_clr && ch_ok) begin
                lpf_q[err_ch] <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pid_dterm_mc.sv
// Self-checking bench for pid_dterm_mc: a sample-list model predicts each
// output pulse; a negedge process compares every cycle; literal values pin the model.
module tb_pid_dterm_mc;
    import pid_dterm_pkg::*;

    localparam int ERR_W   = ERR_W_DEF;
    localparam int SAT_W   = SAT_W_DEF;
    localparam int COEFF_W = COEFF_W_DEF;
    localparam int DEPTH   = DEPTH_DEF;
    localparam int NUM_CH  = NUM_CH_DEF;
    localparam int CH_W    = ch_w_f(NUM_CH_DEF);
    localparam int PROD_W  = SAT_W + COEFF_W;
    localparam int SAT_MAX = (1 << (SAT_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (SAT_W - 1));

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic signed [ERR_W-1:0]   err_sat = '0;
    logic        [CH_W-1:0]    err_ch = '0;
    logic                      err_vld = 1'b0;
    logic                      hist_clr = 1'b0;
    logic signed [COEFF_W-1:0] d_coeff = '0;
    logic signed [PROD_W-1:0]  D_term;
    logic        [CH_W-1:0]    D_ch;
    logic                      D_vld;

    always #5 clk = ~clk;

    pid_dterm_mc dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .err_sat  (err_sat),
        .err_ch   (err_ch),
        .err_vld  (err_vld),
        .hist_clr (hist_clr),
        .d_coeff  (d_coeff),
        .D_term   (D_term),
        .D_ch     (D_ch),
        .D_vld    (D_vld)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        int due;
        int term;
        int ch;
    } exp_t;

    int   cyc = 0;
    int   samp_q [NUM_CH][$];   // every sample since last clear, oldest first
    int   lpf_m  [NUM_CH];
    exp_t exp_q  [$];
    int   last_term = 0;
    int   last_ch = 0;
    int   obs [NUM_CH][$];      // observed terms per channel, in pulse order

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int clamp(input int v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction

    task automatic model_clear(input int ch);
        samp_q[ch].delete();
        lpf_m[ch] = 0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) model_clear(c);
        exp_q.delete();
        last_term = 0;
        last_ch   = 0;
    endtask

    task automatic model_sample(input int ch, input int err, input int coeff, input bit clr);
        int n;
        int diff;
        int term;
        if (clr) model_clear(ch);
        n    = samp_q[ch].size();
        diff = (n >= DEPTH) ? err - samp_q[ch][n - DEPTH] : 0;
        term = clamp(diff) * coeff;
`ifdef PID_DTERM_LPF_EN
        term = (term + lpf_m[ch]) >>> 1;
        lpf_m[ch] = term;
`endif
        samp_q[ch].push_back(err);
        exp_q.push_back('{due: cyc + 2, term: term, ch: ch});
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin : cmp
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("d_vld_pulse", D_vld, 1);
            check("d_term", D_term, e.term);
            check("d_ch", D_ch, e.ch);
            last_term = e.term;
            last_ch   = e.ch;
            if (D_vld === 1'b1) obs[int'(D_ch)].push_back(int'(D_term));
        end else begin
            check("d_vld_idle", D_vld, 0);
            check("d_term_hold", D_term, last_term);
            check("d_ch_hold", D_ch, last_ch);
            if (D_vld === 1'b1) obs[int'(D_ch)].push_back(int'(D_term));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit vld, input int ch, input int err, input int coeff, input bit clr);
        err_vld  = vld;
        err_ch   = ch[CH_W-1:0];
        err_sat  = err[ERR_W-1:0];
        d_coeff  = coeff[COEFF_W-1:0];
        hist_clr = clr;
        if (vld) model_sample(ch, err, coeff, clr);
        else if (clr) model_clear(ch);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    function automatic int last_obs(input int ch);
        if (obs[ch].size() == 0) return 0;
        return obs[ch][obs[ch].size() - 1];
    endfunction

    int prime_v [5] = '{10, 20, 30, 40, 50};
    int iso_ch0 [4] = '{0, 0, 0, 50};
    int iso_ch1 [4] = '{100, 100, 100, 90};
    int n_before;

    initial begin
        #1;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_d_term", D_term, 0);
        check("reset_d_vld", D_vld, 0);
        check("reset_d_ch", D_ch, 0);
        idle(3);

        // Priming: ch0, coeff 7
        foreach (prime_v[i]) drive(1, 0, prime_v[i], 7, 0);
        idle(3);
        check("prime_count", obs[0].size(), 5);
        check("prime_1st", obs[0][0], 0);
        check("prime_3rd", obs[0][2], 0);
`ifdef PID_DTERM_LPF_EN
        check("lpf_1st", obs[0][3], 105);
        check("lpf_2nd", obs[0][4], 157);
`else
        check("prime_4th", obs[0][3], 210);
        check("prime_5th", obs[0][4], 210);
`endif

        // Saturation, positive then negative
        drive(0, 0, 0, 0, 1);
        drive(1, 0, 0, 7, 0);
        drive(1, 0, 0, 7, 0);
        drive(1, 0, 0, 7, 0);
        drive(1, 0, 500, 7, 0);
        idle(3);
`ifndef PID_DTERM_LPF_EN
        check("sat_pos", last_obs(0), 889);
`endif
        drive(1, 0, 511, 7, 0);
        drive(1, 0, 0, 7, 0);
        drive(1, 0, 0, 7, 0);
        drive(1, 0, -512, 7, 0);
        idle(3);
`ifndef PID_DTERM_LPF_EN
        check("sat_neg", last_obs(0), -896);
`endif

        // Channel isolation, interleaved, coeff 2
        drive(0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, iso_ch0[i], 2, 0);
            drive(1, 1, iso_ch1[i], 2, 0);
        end
        idle(3);
`ifndef PID_DTERM_LPF_EN
        check("iso_ch0", last_obs(0), 100);
        check("iso_ch1", last_obs(1), -20);
`endif

        // Clear colliding with a sample on primed ch1, negative coeff
        drive(1, 1, 77, -3, 1);
        drive(1, 1, 80, -3, 0);
        drive(1, 1, 90, -3, 0);
        drive(1, 1, 100, -3, 0);
        idle(3);
        check("clr_coll_0", obs[1][obs[1].size() - 4], 0);
        check("clr_coll_2", obs[1][obs[1].size() - 2], 0);
`ifndef PID_DTERM_LPF_EN
        check("clr_coll_4th", last_obs(1), -69);
`endif

        // Extreme product: sat -128 times coeff -16
        drive(1, 0, -512, -16, 0);
        idle(3);
`ifndef PID_DTERM_LPF_EN
        check("prod_extreme", last_obs(0), 2048);
`endif

        // Reset with two samples in flight: neither may emerge
        n_before = obs[0].size();
        drive(1, 0, 100, 5, 0);
        drive(1, 0, 200, 5, 0);
        err_vld = 1'b0;
        hist_clr = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        check("reset_drop", obs[0].size(), n_before);

        // History emptied by reset: needs full priming again
        drive(1, 0, 300, 5, 0);
        drive(1, 0, 0, 5, 0);
        drive(1, 0, 0, 5, 0);
        drive(1, 0, 0, 5, 0);
        idle(3);
`ifndef PID_DTERM_LPF_EN
        check("post_reset", last_obs(0), -640);
`endif
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
